mem_port_arbiter: RTL

//  Shares one single-port memory bus between the core's instruction-fetch port (to_imem/fr_imem)
//  and data port (to_dmem/fr_dmem), so the core can run from a unified RAM.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/rr_pick2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM state
// encodings, bus owner constants, default widths and counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Wait counter width; a disabled timeout (0) still gets a 1-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the core-side fetch/data ports and the memory-side bus of the
// arbiter. The arbiter uses the slave view; the environment uses master.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    localparam int BW = DW / 8;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    logic          bus_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
               mem_ready, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
               mem_ready, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright; under
// contention the port that did not own the bus last time wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_owner,
    output logic grant_i,
    output logic grant_d
);

    // Grant decision, at most one grant asserted.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (req_i && req_d) begin
            if (last_owner == OWN_I) grant_d = 1'b1;
            else                     grant_i = 1'b1;
        end else if (req_i) begin
            grant_i = 1'b1;
        end else if (req_d) begin
            grant_d = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory bus between the core's instruction-fetch and
// data ports. One transfer at a time, round-robin under contention, with an
// optional wait timeout that completes the transfer with bus_err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 255
)
(
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int BW = DW / 8;
    localparam int CW = cnt_width(TIMEOUT);
    // Last counter value before abort: the bus is held for exactly TIMEOUT cycles.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [BW-1:0] mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          bus_err_q, bus_err_d;
    logic          grant_i, grant_d;
    logic          timed_out;

    rr_pick2 u_pick (
        .req_i      (bus.if_req),
        .req_d      (bus.d_req),
        .last_owner (last_owner_q),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        bus_err_d    = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d      = BUS_I;
                    last_owner_d = OWN_I;
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_be_d     = '1;
                    mem_addr_d   = bus.if_addr;
                end else if (grant_d) begin
                    state_d      = BUS_D;
                    last_owner_d = OWN_D;
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = bus.d_we;
                    mem_be_d     = bus.d_be;
                    mem_addr_d   = bus.d_addr;
                    mem_wdata_d  = bus.d_wdata;
                end
            end
            BUS_I, BUS_D: begin
                if (bus.mem_ready || timed_out) begin
                    // A timed-out transfer returns zero data and flags bus_err.
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    bus_err_d = !bus.mem_ready;
                    if (state_q == BUS_I) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
                    end else begin
                        d_ack_d    = 1'b1;
                        d_rdata_d  = bus.mem_ready ? bus.mem_rdata : '0;
                    end
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_I;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.bus_err   = bus_err_q;

endmodule
